// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared constants and types for the RV32I multicycle control sequencer
//
// Purpose: opcode constants, FSM state codes, datapath select encodings
//          and the one-hot instruction-class record produced by rv_ctrl_decode.
// Ports:   none (package).
package rv_ctrl_pkg;

  // RV32I major opcodes (ir[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Sequencer states
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd5;

  // Next-PC select
  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM   = 2'd1;
  localparam logic [1:0] PC_SEL_ALU   = 2'd2;

  // Write-back source select
  localparam logic [1:0] WB_SEL_ALU   = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD  = 2'd1;
  localparam logic [1:0] WB_SEL_PC4   = 2'd2;

  // ALU operation
  localparam logic [1:0] ALU_OP_ADD   = 2'd0;
  localparam logic [1:0] ALU_OP_FUNCT = 2'd1;
  localparam logic [1:0] ALU_OP_BR    = 2'd2;
  localparam logic [1:0] ALU_OP_PASSB = 2'd3;

  // One-hot instruction class; all-zero means the opcode is not legal
  typedef struct packed {
    logic r;
    logic i_alu;
    logic load;
    logic store;
    logic branch;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
    logic fence;
  } insn_class_t;

endpackage

// File: rtl/rv_ctrl_decode.sv
// rtl/rv_ctrl_decode.sv - opcode classifier for the multicycle control sequencer
//
// Purpose: combinational map of ir[6:0] to a one-hot instruction class and a legal flag.
// Ports:
//   opcode  in  7   instruction register bits [6:0]
//   cls     out     one-hot instruction class (insn_class_t)
//   legal   out 1   opcode is one of the supported RV32I major opcodes
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  output insn_class_t cls,
  output logic        legal
);

  assign cls.r      = (opcode == OPC_OP);
  assign cls.i_alu  = (opcode == OPC_OP_IMM);
  assign cls.load   = (opcode == OPC_LOAD);
  assign cls.store  = (opcode == OPC_STORE);
  assign cls.branch = (opcode == OPC_BRANCH);
  assign cls.jal    = (opcode == OPC_JAL);
  assign cls.jalr   = (opcode == OPC_JALR);
  assign cls.lui    = (opcode == OPC_LUI);
  assign cls.auipc  = (opcode == OPC_AUIPC);
  assign cls.fence  = (opcode == OPC_FENCE);

  assign legal = |cls;

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rtl/rv_multicycle_ctrl.sv - multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for RV32I
//
// Purpose: steps each instruction through the shared single-ALU datapath, handshakes
//          with instruction and data memory, holds the instruction register.
// Optional feature: RV_CTRL_INSTRET_EN adds the 64-bit retired-instruction counter o_instret.
// Ports:
//   i_clk, i_rst_n                   clock (rising edge), async active-low reset
//   o_imem_req / i_imem_valid / i_imem_rdata[31:0]   instruction fetch handshake
//   o_ir[31:0]                       instruction register
//   i_br_taken                       branch compare result (EXEC)
//   o_pc_we, o_pc_sel[1:0]           PC update control
//   o_alu_a_sel, o_alu_b_sel, o_alu_op[1:0]          ALU operand/operation select
//   o_dmem_req, o_dmem_we / i_dmem_done              data memory handshake
//   o_rf_we, o_wb_sel[1:0]           register-file write control
//   o_retire                         one pulse per retired instruction
//   o_trap                           sticky illegal-opcode indication
//   o_instret[63:0]                  retired count (only with RV_CTRL_INSTRET_EN)
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ir,
  input  logic        i_br_taken,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_alu_a_sel,
  output logic        o_alu_b_sel,
  output logic [1:0]  o_alu_op,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  input  logic        i_dmem_done,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_retire,
  output logic        o_trap
`ifdef RV_CTRL_INSTRET_EN
  ,
  output logic [63:0] o_instret
`endif
);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  insn_class_t cls;
  logic        legal;

  rv_ctrl_decode u_decode (
    .opcode (o_ir[6:0]),
    .cls    (cls),
    .legal  (legal)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FETCH;
      o_ir    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH && i_imem_valid) begin
        o_ir <= i_imem_rdata;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    o_imem_req  = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = PC_SEL_PLUS4;
    o_alu_a_sel = 1'b0;
    o_alu_b_sel = 1'b0;
    o_alu_op    = ALU_OP_ADD;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_rf_we     = 1'b0;
    o_wb_sel    = WB_SEL_ALU;
    o_retire    = 1'b0;
    o_trap      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // State sits at FETCH while reset is held; keep the request quiet until release.
        o_imem_req = i_rst_n;
        if (i_imem_valid) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        if (!legal) begin
          state_d = ST_TRAP;
        end else if (cls.fence) begin
          o_pc_we  = 1'b1;
          o_retire = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cls.r) o_alu_op = ALU_OP_FUNCT;
        if (cls.i_alu) begin
          o_alu_b_sel = 1'b1;
          o_alu_op    = ALU_OP_FUNCT;
        end
        if (cls.load || cls.store || cls.jalr) o_alu_b_sel = 1'b1;
        if (cls.auipc) begin
          o_alu_a_sel = 1'b1;
          o_alu_b_sel = 1'b1;
        end
        if (cls.lui) begin
          o_alu_b_sel = 1'b1;
          o_alu_op    = ALU_OP_PASSB;
        end
        if (cls.branch) begin
          o_alu_op = ALU_OP_BR;
          o_pc_we  = 1'b1;
          o_pc_sel = i_br_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
          o_retire = 1'b1;
          state_d  = ST_FETCH;
        end else if (cls.load || cls.store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end

      ST_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = cls.store;
        // A store retires in the same cycle its access completes.
        if (i_dmem_done) begin
          if (cls.store) begin
            o_pc_we  = 1'b1;
            o_retire = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        o_rf_we  = 1'b1;
        o_pc_we  = 1'b1;
        o_retire = 1'b1;
        if (cls.load)                o_wb_sel = WB_SEL_LOAD;
        else if (cls.jal || cls.jalr) o_wb_sel = WB_SEL_PC4;
        if (cls.jal)       o_pc_sel = PC_SEL_IMM;
        else if (cls.jalr) o_pc_sel = PC_SEL_ALU;
        state_d = ST_FETCH;
      end

      ST_TRAP: begin
        o_trap = 1'b1;
      end

      default: begin
        // Unused state encodings are treated as a fault.
        state_d = ST_TRAP;
      end
    endcase
  end

`ifdef RV_CTRL_INSTRET_EN
  logic [63:0] instret_q;

  // Wraps naturally at 2^64; TRAP never retires so it never counts there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instret_q <= '0;
    end else if (o_retire) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign o_instret = instret_q;
`endif

endmodule

// File: doc/rv_multicycle_ctrl.md
# rv_multicycle_ctrl

Multicycle control sequencer for the RV32I core. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with instruction and data memory. Holds the instruction register that feeds the immediate generator. Drives the PC, ALU, register-file and write-back select controls of the shared single-ALU datapath.

## Interface
- No parameters.
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- o_imem_req  out  1  fetch request
- i_imem_valid  in  1  fetch data valid
- i_imem_rdata  in  32  fetched instruction
- o_ir  out  32  instruction register, to decode and immediate generator
- i_br_taken  in  1  branch-compare result from ALU, valid in EXEC
- o_pc_we  out  1  PC write enable
- o_pc_sel  out  2  selects next PC: 0 = PC+4, 1 = PC+imm, 2 = ALU result & ~1
- o_alu_a_sel  out  1  ALU A operand: 0 = rs1, 1 = PC
- o_alu_b_sel  out  1  ALU B operand: 0 = rs2, 1 = imm
- o_alu_op  out  2  ALU operation: 0 = add, 1 = funct-decoded, 2 = branch compare, 3 = pass B
- o_dmem_req  out  1  data memory request
- o_dmem_we  out  1  data memory write (store)
- i_dmem_done  in  1  data access complete; load data valid
- o_rf_we  out  1  register-file write
- o_wb_sel  out  2  write-back source: 0 = ALU, 1 = load data, 2 = PC+4
- o_retire  out  1  one-cycle pulse per retired instruction
- o_trap  out  1  sticky: illegal opcode seen

## Operation
- State register values: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- All outputs except o_ir are combinational from the state, o_ir[6:0] and i_br_taken.
- **FETCH:** o_imem_req=1 until i_imem_valid. On req&&valid, o_ir <= i_imem_rdata and go to DECODE. i_imem_valid is ignored in other states.
- **DECODE:** classifies the opcode.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111.
  - FENCE (0001111): pc_we=1, pc_sel=0, retire, go to FETCH.
  - Any other opcode: go to TRAP.
  - Otherwise go to EXEC.
- **EXEC:**
  - R: a=rs1, b=rs2, op=1.
  - I-ALU: b=imm, op=1.
  - LOAD/STORE/JALR: b=imm, op=0.
  - AUIPC: a=PC, b=imm, op=0.
  - LUI: b=imm, op=3.
  - JAL: no ALU use.
  - BRANCH: op=2, pc_we=1, pc_sel = i_br_taken ? 1 : 0, retire, go to FETCH.
  - LOAD/STORE go to MEM; all others go to WB.
- **MEM:** o_dmem_req=1 held until i_dmem_done; dmem_we=1 for STORE.
  - On done: STORE does pc_we (sel 0), retire, go to FETCH.
  - On done: LOAD goes to WB.
- **WB:** rf_we=1 and pc_we=1 on the same edge.
  - wb_sel: LOAD=1, JAL/JALR=2, else 0.
  - pc_sel: JAL=1, JALR=2, else 0.
  - Retire, go to FETCH.
- **TRAP:** o_trap=1, all other controls 0. Exit only by reset.
- Datapath must hold the ALU result register across EXEC→MEM/WB.

## Timing
- Reset (async assert, any state): state=FETCH, o_ir=0, o_trap=0. All controls deassert immediately. o_imem_req=1 in the first cycle after deassertion.
- Zero-wait latencies, cycles per instruction: branch 3, store 4, ALU/LUI/AUIPC/JAL/JALR 4, load 5, FENCE 2.
- Each memory wait cycle adds 1 cycle.
- Exactly one o_retire pulse per instruction, in its final cycle, coincident with o_pc_we.
- No back-to-back overlap: the next fetch request starts the cycle after retire.
- i_imem_valid and i_dmem_done asserted in the same cycle the request rises are accepted in that cycle.

## Configuration
- RV_CTRL_INSTRET_EN defined:
  - Adds output port o_instret, 64 bits.
  - Resets to 0; increments on each o_retire.
  - Wraps 2^64-1 → 0.
  - Not incremented in TRAP.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Package rv_ctrl_pkg holds:
  - opcode constants
  - state enumeration
  - pc_sel, wb_sel and alu_op encodings
- Sub-module rv_ctrl_decode: combinational, o_ir[6:0] → one-hot instruction class plus legal flag. Used by the FSM and the output logic.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with zero-wait imem → FETCH→DECODE→EXEC→WB. In WB: rf_we=1, wb_sel=0, pc_we=1, retire=1. Total 4 cycles.
- LW 0x0000A103, dmem_done after 2 wait cycles → dmem_req held 3 cycles with dmem_we=0. In WB: wb_sel=1. Retire at cycle 7.
- SW 0x0020A223 → dmem_req=1, dmem_we=1. Retire and pc_we (sel 0) on done. No rf_we at any point.
- BEQ 0x00000463: with i_br_taken=1 → pc_sel=1 in EXEC, retire at cycle 3. With i_br_taken=0 → pc_sel=0.
- JAL 0x008000EF then instruction 0xFFFFFFFF:
  - JAL: wb_sel=2, pc_sel=1 in WB.
  - 0xFFFFFFFF: o_trap=1 from the cycle after DECODE; no further imem_req.
  - Async reset mid-trap clears to FETCH.
- With RV_CTRL_INSTRET_EN: 10 retired instructions → o_instret=10. Counter preset near wrap by force → rolls over to 0.
